// File: rtl/perf_event_counters_pkg.sv
// Shared definitions for the performance event counter block.
// Holds the FSM state encoding and the read-select index of the cycle counter.
package perf_event_counters_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // The cycle counter sits just past the last event channel in the read map.
    function automatic int cyc_sel_idx(input int num_evt);
        return num_evt;
    endfunction

endpackage

// File: rtl/perf_event_counters_sat.sv
// Single counter with clear, increment, sticky overflow flag and optional
// saturation at all-ones (otherwise wraps to zero).
module perf_sat_counter #(
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] value,
    output logic             ovf
);

    logic [CNT_W-1:0] value_q, value_d;
    logic             ovf_q, ovf_d;

    // Next value: clear wins over increment; an increment from all-ones flags overflow.
    always_comb begin
        value_d = value_q;
        ovf_d   = ovf_q;
        if (clr) begin
            value_d = '0;
            ovf_d   = 1'b0;
        end else if (inc) begin
            if (&value_q) begin
                ovf_d   = 1'b1;
                value_d = SATURATE ? value_q : '0;
            end else begin
                value_d = value_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            value_d = value_q;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            ovf_q   <= ovf_d;
        end
    end

    assign value = value_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/perf_event_counters.sv
// Performance event counters: per-channel event counters plus a cycle counter,
// gated by an IDLE/COUNT/HALTED window FSM, with a one-cycle registered read port.
module perf_event_counters
    import perf_event_counters_pkg::*;
#(
    parameter int NUM_EVT  = 4,
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             halt,
    input  logic                             clr,
    input  logic [NUM_EVT-1:0]               evt,
    input  logic                             rd_en,
    input  logic [$clog2(NUM_EVT+1)-1:0]     rd_sel,
    output logic [CNT_W-1:0]                 rd_data,
    output logic                             rd_ovf,
    output logic                             rd_valid,
    output logic [1:0]                       state,
    output logic [CNT_W-1:0]                 cycle_count
);

    localparam int SEL_W    = $clog2(NUM_EVT+1);
    localparam int NUM_SLOT = 1 << SEL_W;
    localparam int CYC_IDX  = cyc_sel_idx(NUM_EVT);

    state_e              state_q, state_d;
    logic                counting_s;
    logic [CNT_W-1:0]    slot_val_s [NUM_SLOT];
    logic [NUM_SLOT-1:0] slot_ovf_s;
    logic [CNT_W-1:0]    rd_data_q, rd_data_d;
    logic                rd_ovf_q, rd_ovf_d;
    logic                rd_valid_q, rd_valid_d;

    assign counting_s = (state_q == ST_COUNT);

    // Unused read slots beyond the cycle counter read back as zero.
    for (genvar i = 0; i < NUM_SLOT; i++) begin : g_slot
        if (i == CYC_IDX) begin : g_cyc
            perf_sat_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (counting_s),
                .clr   (clr),
                .value (slot_val_s[i]),
                .ovf   (slot_ovf_s[i])
            );
        end else if (i < NUM_EVT) begin : g_evt
            perf_sat_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (counting_s & evt[i]),
                .clr   (clr),
                .value (slot_val_s[i]),
                .ovf   (slot_ovf_s[i])
            );
        end else begin : g_none
            assign slot_val_s[i] = '0;
            assign slot_ovf_s[i] = 1'b0;
        end
    end

    // Window FSM: clr inside COUNT suppresses a simultaneous halt.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_COUNT;
                else       state_d = ST_IDLE;
            end
            ST_COUNT: begin
                if (!clr && halt) state_d = ST_HALTED;
                else              state_d = ST_COUNT;
            end
            ST_HALTED: begin
                if (clr) state_d = ST_IDLE;
                else     state_d = ST_HALTED;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read port samples the pre-edge counter values; data holds when not reading.
    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        rd_ovf_d   = rd_ovf_q;
        if (rd_en) begin
            rd_data_d = slot_val_s[rd_sel];
            rd_ovf_d  = slot_ovf_s[rd_sel];
        end else begin
            rd_data_d = rd_data_q;
            rd_ovf_d  = rd_ovf_q;
        end
    end

    // FSM and read-port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ovf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_ovf_q   <= rd_ovf_d;
        end
    end

    assign state       = state_q;
    assign rd_data     = rd_data_q;
    assign rd_ovf      = rd_ovf_q;
    assign rd_valid    = rd_valid_q;
    assign cycle_count = slot_val_s[CYC_IDX];

endmodule

// File: tb/tb_perf_event_counters.sv
// Bench for perf_event_counters: a saturating and a wrapping 8-bit instance share
// stimulus; a table, directed sequences and random traffic are checked against a count model.
module tb_perf_event_counters;

    logic       clk = 1'b0;
    logic       rst, start, halt, clr, rd_en;
    logic [3:0] evt;
    logic [2:0] rd_sel;

    logic [7:0] s_rd_data, w_rd_data, s_cyc, w_cyc;
    logic       s_rd_ovf, w_rd_ovf, s_rd_valid, w_rd_valid;
    logic [1:0] s_state, w_state;

    int checks   = 0;
    int failures = 0;

    // Reference model: true (unbounded) counts, converted per instance flavour.
    int     m_state;
    longint m_cnt [5];
    bit     m_rdv;
    longint m_rd;

    always #5 clk = ~clk;

    perf_event_counters #(.NUM_EVT(4), .CNT_W(8), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .clr(clr), .evt(evt),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(s_rd_data), .rd_ovf(s_rd_ovf),
        .rd_valid(s_rd_valid), .state(s_state), .cycle_count(s_cyc)
    );

    perf_event_counters #(.NUM_EVT(4), .CNT_W(8), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .clr(clr), .evt(evt),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(w_rd_data), .rd_ovf(w_rd_ovf),
        .rd_valid(w_rd_valid), .state(w_state), .cycle_count(w_cyc)
    );

    function automatic longint sat8(input longint c);
        return (c > 255) ? 64'd255 : c;
    endfunction

    function automatic longint wrap8(input longint c);
        return c % 256;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; start = 1'b0; halt = 1'b0; clr = 1'b0;
        evt = 4'd0; rd_en = 1'b0; rd_sel = 3'd0;
    endtask

    task automatic model_update();
        if (rst) begin
            m_state = 0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_rdv = 1'b0;
            m_rd  = 0;
        end else begin
            m_rdv = rd_en;
            if (rd_en) m_rd = (rd_sel <= 3'd4) ? m_cnt[rd_sel] : 0;
            if (clr) begin
                foreach (m_cnt[i]) m_cnt[i] = 0;
            end else if (m_state == 1) begin
                m_cnt[4]++;
                for (int i = 0; i < 4; i++) if (evt[i]) m_cnt[i]++;
            end
            case (m_state)
                0: if (start) m_state = 1;
                1: if (!clr && halt) m_state = 2;
                2: if (clr) m_state = 0;
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic model_compare();
        chk("sat_state",    s_state,    m_state[1:0]);
        chk("wrap_state",   w_state,    m_state[1:0]);
        chk("sat_cycle",    s_cyc,      sat8(m_cnt[4]));
        chk("wrap_cycle",   w_cyc,      wrap8(m_cnt[4]));
        chk("sat_rd_valid", s_rd_valid, m_rdv);
        chk("wrap_rd_valid",w_rd_valid, m_rdv);
        chk("sat_rd_data",  s_rd_data,  sat8(m_rd));
        chk("wrap_rd_data", w_rd_data,  wrap8(m_rd));
        chk("sat_rd_ovf",   s_rd_ovf,   m_rd > 255);
        chk("wrap_rd_ovf",  w_rd_ovf,   m_rd > 255);
    endtask

    // One clock: model consumes the pre-edge inputs, outputs checked 1ns after the edge.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        model_compare();
    endtask

    typedef struct {
        logic       rst, start, halt, clr;
        logic [3:0] evt;
        logic       rd_en;
        logic [2:0] rd_sel;
        logic [1:0] e_state;
        logic [7:0] e_cyc;
        logic       e_rdv;
        logic [7:0] e_rdd;
        logic       e_ovf;
    } vec_t;

    vec_t tbl [11];

    initial begin
        //            rst   start halt  clr   evt      rd_en rd_sel  state  cyc    rdv   rdd    ovf
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 2'd0, 8'd0, 1'b0, 8'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd0, 2'd1, 8'd0, 1'b0, 8'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd0, 2'd1, 8'd1, 1'b0, 8'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b1, 3'd0, 2'd1, 8'd2, 1'b1, 8'd1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b1, 3'd1, 2'd2, 8'd3, 1'b1, 8'd1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 3'd0, 2'd2, 8'd3, 1'b1, 8'd3, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd4, 2'd2, 8'd3, 1'b1, 8'd3, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd7, 2'd2, 8'd3, 1'b1, 8'd0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 2'd2, 8'd3, 1'b0, 8'd0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 2'd0, 8'd0, 1'b0, 8'd0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd0, 2'd0, 8'd0, 1'b1, 8'd0, 1'b0};

        idle_inputs();
        m_state = 0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_rdv = 1'b0;
        m_rd  = 0;

        // Table-driven vectors from reset.
        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rst; start = tbl[i].start; halt = tbl[i].halt; clr = tbl[i].clr;
            evt = tbl[i].evt; rd_en = tbl[i].rd_en; rd_sel = tbl[i].rd_sel;
            step();
            chk($sformatf("tbl%0d_state", i), s_state,    tbl[i].e_state);
            chk($sformatf("tbl%0d_cyc", i),   s_cyc,      tbl[i].e_cyc);
            chk($sformatf("tbl%0d_rdv", i),   s_rd_valid, tbl[i].e_rdv);
            chk($sformatf("tbl%0d_rdd", i),   s_rd_data,  tbl[i].e_rdd);
            chk($sformatf("tbl%0d_ovf", i),   s_rd_ovf,   tbl[i].e_ovf);
        end

        // Ten event cycles, halt on the tenth; later events ignored.
        idle_inputs(); rst = 1'b1; step();
        idle_inputs(); start = 1'b1; step();
        for (int i = 1; i <= 10; i++) begin
            idle_inputs(); evt = 4'b0001; halt = (i == 10); step();
        end
        chk("win_state", s_state, 2'd2);
        idle_inputs(); evt = 4'b1111; rd_en = 1'b1; rd_sel = 3'd0; step();
        chk("win_evt0", s_rd_data, 8'd10);
        idle_inputs(); evt = 4'b1111; rd_en = 1'b1; rd_sel = 3'd4; step();
        chk("win_cycles", s_rd_data, 8'd10);

        // Saturate vs wrap: evt[1] for 300 cycles, evt[2] for 260 cycles.
        idle_inputs(); rst = 1'b1; step();
        idle_inputs(); start = 1'b1; step();
        for (int i = 0; i < 300; i++) begin
            idle_inputs(); evt = {1'b0, (i < 260), 1'b1, 1'b0}; step();
        end
        idle_inputs(); halt = 1'b1; step();
        idle_inputs(); rd_en = 1'b1; rd_sel = 3'd1; step();
        chk("sat_cnt1_data", s_rd_data, 8'hFF);
        chk("sat_cnt1_ovf",  s_rd_ovf,  1'b1);
        idle_inputs(); rd_en = 1'b1; rd_sel = 3'd2; step();
        chk("wrap_cnt2_data", w_rd_data, 8'd4);
        chk("wrap_cnt2_ovf",  w_rd_ovf,  1'b1);
        idle_inputs(); clr = 1'b1; step();
        idle_inputs(); rd_en = 1'b1; rd_sel = 3'd1; step();
        chk("sat_clr_data", s_rd_data, 8'd0);
        chk("sat_clr_ovf",  s_rd_ovf,  1'b0);

        // clr and halt together while counting.
        idle_inputs(); start = 1'b1; step();
        for (int i = 0; i < 5; i++) begin idle_inputs(); evt = 4'b1111; step(); end
        idle_inputs(); clr = 1'b1; halt = 1'b1; evt = 4'b1111; step();
        chk("clrhalt_state", s_state, 2'd1);
        for (int s = 0; s < 4; s++) begin
            idle_inputs(); rd_en = 1'b1; rd_sel = 3'(s); step();
            chk($sformatf("clrhalt_cnt%0d", s), s_rd_data, 8'd0);
        end

        // Back-to-back reads walking 0..5 while counting.
        for (int i = 0; i < 12; i++) begin
            idle_inputs(); evt = 4'(i); rd_en = 1'b1; rd_sel = 3'(i % 6); step();
            chk("walk_rdv", s_rd_valid, 1'b1);
            if (i % 6 == 4) chk("walk_cyc_minus1", s_rd_data, 8'(s_cyc - 8'd1));
            if (i % 6 == 5) chk("walk_sel5_zero", s_rd_data, 8'd0);
        end

        // Reset mid-count with a read pending.
        idle_inputs(); rst = 1'b1; rd_en = 1'b1; rd_sel = 3'd4; evt = 4'b1111; step();
        chk("rst_state", s_state, 2'd0);
        chk("rst_rdv",   s_rd_valid, 1'b0);
        for (int s = 0; s < 5; s++) begin
            idle_inputs(); rd_en = 1'b1; rd_sel = 3'(s); step();
            chk($sformatf("rst_cnt%0d", s), s_rd_data, 8'd0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rst    = ($urandom_range(0, 299) == 0);
            clr    = ($urandom_range(0, 249) == 0);
            halt   = ($urandom_range(0, 149) == 0);
            start  = ($urandom_range(0, 7) == 0);
            evt    = 4'($urandom);
            rd_en  = 1'($urandom);
            rd_sel = 3'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
